timer_seq: RTL

TIMER_SEQ -- requirements
Module: timer_seq

---
 rtl/timer_seq.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/timer_seq.sv
// timer_seq: Wishbone master that programs a timer block, counts a requested
// number of expiries (irq + status read), then disables the timer.
module timer_seq #(
   parameter logic [31:0] TIMER_BASE = 32'h0,
   parameter int          ACK_TMO    = 16
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic [31:0] i_period,
   input  logic [7:0]  i_reps,
   input  logic        i_abort,
   input  logic        i_irq,
   output logic        o_wb_cyc,
   output logic        o_wb_stb,
   output logic        o_wb_wen,
   output logic [31:0] o_wb_adr,
   output logic [31:0] o_wb_dat,
   output logic [3:0]  o_wb_sel,
   input  logic        i_wb_ack,
   input  logic [31:0] i_wb_dat,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_err,
   output logic [7:0]  o_count
);

   typedef enum logic [2:0] {
      IDLE, WR_EN, WR_PR, WR_ST, WAIT_IRQ, RD_AK, WR_DIS, FIN
   } state_t;

   localparam logic [31:0] TMO_LAST = 32'(ACK_TMO - 1);

   state_t      state_q, state_d;
   logic        req_q, req_d;          // bus request held until ack/timeout
   logic [31:0] tmo_q, tmo_d;          // cycles spent waiting for ack
   logic        err_q, err_d;          // sequence will end with o_err
   logic        tmo_err_q, tmo_err_d;  // one-cycle error pulse after timeout
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  reps_q, reps_d;
   logic [31:0] period_q, period_d;
   logic [7:0]  inc_c;
   logic        bus_c;
   logic [31:0] adr_off_c, wdat_c;
   logic        wen_c;

   // Only bit0 of the status word carries meaning.
   logic        unused_rdat;
   assign unused_rdat = ^i_wb_dat[31:1];

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign bus_c = (state_q == WR_EN) || (state_q == WR_PR) || (state_q == WR_ST) ||
                  (state_q == RD_AK) || (state_q == WR_DIS);

   // State and datapath registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= IDLE;
         req_q     <= 1'b0;
         tmo_q     <= 32'd0;
         err_q     <= 1'b0;
         tmo_err_q <= 1'b0;
         cnt_q     <= 8'd0;
         reps_q    <= 8'd0;
         period_q  <= 32'd0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         tmo_q     <= tmo_d;
         err_q     <= err_d;
         tmo_err_q <= tmo_err_d;
         cnt_q     <= cnt_d;
         reps_q    <= reps_d;
         period_q  <= period_d;
      end
   end

   // Sequencer next state, bus request handshake and ack timeout
   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      tmo_d     = tmo_q;
      err_d     = err_q;
      tmo_err_d = 1'b0;
      cnt_d     = cnt_q;
      reps_d    = reps_q;
      period_d  = period_q;
      inc_c     = sat_inc(cnt_q);

      // Abort during a sequencer-owned bus cycle is remembered; the cycle
      // still finishes and the ack decides where to go.
      if (i_abort && ((state_q == WR_EN) || (state_q == WR_PR) ||
                      (state_q == WR_ST) || (state_q == RD_AK)))
         err_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (i_start) begin
               reps_d   = i_reps;
               period_d = i_period;
               err_d    = 1'b0;
               if (i_reps == 8'd0) begin
                  state_d = FIN;
               end else begin
                  cnt_d   = 8'd0;
                  state_d = WR_EN;
               end
            end
         end
         WR_EN:  if (req_q && i_wb_ack) state_d = err_d ? WR_DIS : WR_PR;
         WR_PR:  if (req_q && i_wb_ack) state_d = err_d ? WR_DIS : WR_ST;
         WR_ST:  if (req_q && i_wb_ack) state_d = err_d ? WR_DIS : WAIT_IRQ;
         WAIT_IRQ: begin
            if (i_abort) begin
               err_d   = 1'b1;
               state_d = WR_DIS;
            end else if (i_irq) begin
               state_d = RD_AK;
            end
         end
         RD_AK: begin
            if (req_q && i_wb_ack) begin
               if (i_wb_dat[0]) begin
                  cnt_d = inc_c;
                  if (!err_d && (inc_c < reps_q)) state_d = WR_ST;
                  else                            state_d = WR_DIS;
               end else begin
                  err_d   = 1'b1;
                  state_d = WR_DIS;
               end
            end
         end
         WR_DIS: if (req_q && i_wb_ack) state_d = FIN;
         FIN:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // The first cycle in each bus state is left idle, which also gives the
      // mandatory gap between consecutive bus cycles.
      if (bus_c) begin
         if (!req_q) begin
            req_d = 1'b1;
            tmo_d = 32'd0;
         end else if (i_wb_ack) begin
            req_d = 1'b0;
            tmo_d = 32'd0;
         end else if (tmo_q == TMO_LAST) begin
            req_d     = 1'b0;
            tmo_d     = 32'd0;
            tmo_err_d = 1'b1;
            state_d   = IDLE;
         end else begin
            tmo_d = tmo_q + 32'd1;
         end
      end
   end

   // Register offset, write data and direction for the current bus state
   always_comb begin
      adr_off_c = 32'h0;
      wdat_c    = 32'h0;
      wen_c     = 1'b0;
      case (state_q)
         WR_EN:  begin adr_off_c = 32'h0; wdat_c = 32'h1;    wen_c = 1'b1; end
         WR_PR:  begin adr_off_c = 32'h4; wdat_c = period_q; wen_c = 1'b1; end
         WR_ST:  begin adr_off_c = 32'hC; wdat_c = 32'h1;    wen_c = 1'b1; end
         RD_AK:  begin adr_off_c = 32'h8; wdat_c = 32'h0;    wen_c = 1'b0; end
         WR_DIS: begin adr_off_c = 32'h0; wdat_c = 32'h0;    wen_c = 1'b1; end
         default: ;
      endcase
   end

   // stb is masked by ack so the slave never samples a request in its ack cycle
   assign o_wb_cyc = req_q & ~i_wb_ack;
   assign o_wb_stb = req_q & ~i_wb_ack;
   assign o_wb_wen = req_q & wen_c;
   assign o_wb_sel = req_q ? 4'hF : 4'h0;
   assign o_wb_adr = req_q ? (TIMER_BASE + adr_off_c) : 32'h0;
   assign o_wb_dat = req_q ? wdat_c : 32'h0;

   assign o_busy  = (state_q != IDLE);
   assign o_done  = (state_q == FIN) & ~err_q;
   assign o_err   = ((state_q == FIN) & err_q) | tmo_err_q;
   assign o_count = cnt_q;

endmodule
